// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the memory-access stage and its data-bus helpers.
package mem_lsu_pkg;

    localparam int unsigned DbusAddrBus = 32;
    localparam int unsigned DbusDataBus = 32;
    localparam int unsigned DbusBeBus   = 4;

    // Access size codes; 2'b11 falls through to word handling.
    localparam logic [1:0] MemByte = 2'b00;
    localparam logic [1:0] MemHalf = 2'b01;
    localparam logic [1:0] MemWord = 2'b10;

    typedef enum logic [2:0] {
        LsuIdle  = 3'd0,
        LsuReq   = 3'd1,
        LsuWait  = 3'd2,
        LsuDone  = 3'd3,
        LsuDrain = 3'd4
    } lsu_state_e;

    // Instruction fields captured when a bus access is issued.
    typedef struct packed {
        logic [31:0]            inst;
        logic [31:0]            instaddr;
        logic                   regs_wen;
        logic [4:0]             rd_addr;
        logic [31:0]            rd_data;
        logic                   csr_wen;
        logic [11:0]            csr_addr;
        logic [31:0]            csr_data;
        logic                   we;
        logic [1:0]             size;
        logic                   uns;
        logic [DbusAddrBus-1:0] addr;
        logic [DbusBeBus-1:0]   be;
        logic [DbusDataBus-1:0] wdata;
    } lsu_req_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MemByte: return 1'b0;
            MemHalf: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for the data bus: store enables/replication, load lane select and extension.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]             addr_lo_i,
    input  logic [1:0]             size_i,
    input  logic                   unsigned_i,
    input  logic [DbusDataBus-1:0] st_data_i,
    input  logic [DbusDataBus-1:0] ld_data_i,
    output logic [DbusBeBus-1:0]   be_o,
    output logic [DbusDataBus-1:0] st_data_o,
    output logic [DbusDataBus-1:0] ld_data_o,
    output logic                   misalign_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Pick the addressed byte and halfword out of the returned word.
    always_comb begin
        case (addr_lo_i)
            2'd0:    ld_byte = ld_data_i[7:0];
            2'd1:    ld_byte = ld_data_i[15:8];
            2'd2:    ld_byte = ld_data_i[23:16];
            default: ld_byte = ld_data_i[31:24];
        endcase
        ld_half = addr_lo_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
    end

    // Size-dependent enables, store replication and load extension.
    always_comb begin
        misalign_o = is_misaligned(size_i, addr_lo_i);
        case (size_i)
            MemByte: begin
                be_o      = 4'b0001 << addr_lo_i;
                st_data_o = {4{st_data_i[7:0]}};
                ld_data_o = unsigned_i ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            MemHalf: begin
                be_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
                st_data_o = {2{st_data_i[15:0]}};
                ld_data_o = unsigned_i ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: begin
                be_o      = '1;
                st_data_o = st_data_i;
                ld_data_o = ld_data_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access pipeline stage: issues loads/stores on the req/gnt/rvalid data bus and stalls while outstanding.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            inst_i,
    input  logic [31:0]            instaddr_i,
    input  logic                   regs_wen_i,
    input  logic [4:0]             rd_addr_i,
    input  logic [31:0]            rd_data_i,
    input  logic                   csr_wen_i,
    input  logic [11:0]            csr_wr_addr_i,
    input  logic [31:0]            csr_wr_data_i,
    input  logic                   mem_req_i,
    input  logic                   mem_we_i,
    input  logic [1:0]             mem_size_i,
    input  logic                   mem_unsigned_i,
    input  logic [31:0]            mem_addr_i,
    input  logic [31:0]            mem_wdata_i,
    input  logic                   flush_i,
    output logic                   dbus_req_o,
    output logic                   dbus_we_o,
    output logic [DbusBeBus-1:0]   dbus_be_o,
    output logic [DbusAddrBus-1:0] dbus_addr_o,
    output logic [DbusDataBus-1:0] dbus_wdata_o,
    input  logic                   dbus_gnt_i,
    input  logic                   dbus_rvalid_i,
    input  logic                   dbus_err_i,
    input  logic [DbusDataBus-1:0] dbus_rdata_i,
    output logic                   stall_o,
    output logic [31:0]            inst_o,
    output logic [31:0]            instaddr_o,
    output logic                   regs_wen_o,
    output logic [4:0]             rd_addr_o,
    output logic [31:0]            rd_data_o,
    output logic                   csr_wen_o,
    output logic [11:0]            csr_wr_addr_o,
    output logic [31:0]            csr_wr_data_o,
    output logic                   misalign_o,
    output logic                   fault_o,
    output logic [31:0]            fault_addr_o
);

    // Wide enough for BUS_TIMEOUT+1, the largest value reachable when gnt lands on the last REQ cycle.
    localparam int unsigned CntW = $clog2(BUS_TIMEOUT + 2);

    lsu_state_e             state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    lsu_req_t               req_q, req_d;
    logic [DbusDataBus-1:0] rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   tmo_q, tmo_d;

    logic                   idle, misalign, timeout;
    logic [DbusBeBus-1:0]   al_be;
    logic [DbusDataBus-1:0] al_wdata, ld_ext;

    assign idle    = (state_q == LsuIdle);
    assign timeout = (32'(cnt_q) + 32'd1 >= BUS_TIMEOUT);

    // One aligner serves both directions: live inputs while issuing, latched fields afterwards.
    lsu_align u_align (
        .addr_lo_i  (idle ? mem_addr_i[1:0] : req_q.addr[1:0]),
        .size_i     (idle ? mem_size_i : req_q.size),
        .unsigned_i (idle ? mem_unsigned_i : req_q.uns),
        .st_data_i  (mem_wdata_i),
        .ld_data_i  (rdata_q),
        .be_o       (al_be),
        .st_data_o  (al_wdata),
        .ld_data_o  (ld_ext),
        .misalign_o (misalign)
    );

    // Next-state, request capture, timeout counting and bus request/stall generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        dbus_req_o = 1'b0;
        stall_o    = 1'b0;
        case (state_q)
            LsuIdle: begin
                cnt_d = '0;
                err_d = 1'b0;
                tmo_d = 1'b0;
                if (mem_req_i && !flush_i && !misalign) begin
                    dbus_req_o     = 1'b1;
                    stall_o        = 1'b1;
                    req_d.inst     = inst_i;
                    req_d.instaddr = instaddr_i;
                    req_d.regs_wen = regs_wen_i;
                    req_d.rd_addr  = rd_addr_i;
                    req_d.rd_data  = rd_data_i;
                    req_d.csr_wen  = csr_wen_i;
                    req_d.csr_addr = csr_wr_addr_i;
                    req_d.csr_data = csr_wr_data_i;
                    req_d.we       = mem_we_i;
                    req_d.size     = mem_size_i;
                    req_d.uns      = mem_unsigned_i;
                    req_d.addr     = mem_addr_i;
                    req_d.be       = al_be;
                    req_d.wdata    = al_wdata;
                    state_d        = dbus_gnt_i ? LsuWait : LsuReq;
                end
            end
            LsuReq: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + CntW'(1);
                if (flush_i) begin
                    state_d = LsuIdle;
                end else begin
                    dbus_req_o = 1'b1;
                    if (dbus_gnt_i) begin
                        state_d = LsuWait;
                    end else if (timeout) begin
                        state_d = LsuDone;
                        tmo_d   = 1'b1;
                    end
                end
            end
            LsuWait: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + CntW'(1);
                if (dbus_rvalid_i) begin
                    // A response arriving with the flush completes the drain in the same cycle.
                    state_d = flush_i ? LsuIdle : LsuDone;
                    rdata_d = dbus_rdata_i;
                    err_d   = dbus_err_i;
                end else if (flush_i) begin
                    state_d = LsuDrain;
                end else if (timeout) begin
                    state_d = LsuDone;
                    tmo_d   = 1'b1;
                end
            end
            LsuDrain: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + CntW'(1);
                // The timeout also bounds the drain so a silent bus cannot hang the core.
                if (dbus_rvalid_i || timeout) begin
                    state_d = LsuIdle;
                end
            end
            LsuDone: begin
                state_d = LsuIdle;
            end
            default: begin
                state_d = LsuIdle;
            end
        endcase
    end

    // Bus address/data: computed live while issuing, held from the capture while in REQ.
    always_comb begin
        dbus_we_o    = idle ? mem_we_i : req_q.we;
        dbus_be_o    = idle ? al_be : req_q.be;
        dbus_wdata_o = idle ? al_wdata : req_q.wdata;
        dbus_addr_o  = idle ? {mem_addr_i[31:2], 2'b00} : {req_q.addr[31:2], 2'b00};
    end

    // mem_wb-facing outputs: pass-through in IDLE, captured fields with extended load data in DONE.
    always_comb begin
        inst_o        = inst_i;
        instaddr_o    = instaddr_i;
        regs_wen_o    = regs_wen_i;
        rd_addr_o     = rd_addr_i;
        rd_data_o     = rd_data_i;
        csr_wen_o     = csr_wen_i;
        csr_wr_addr_o = csr_wr_addr_i;
        csr_wr_data_o = csr_wr_data_i;
        misalign_o    = 1'b0;
        fault_o       = 1'b0;
        fault_addr_o  = '0;
        if (!idle) begin
            inst_o        = req_q.inst;
            instaddr_o    = req_q.instaddr;
            rd_addr_o     = req_q.rd_addr;
            rd_data_o     = req_q.we ? req_q.rd_data : ld_ext;
            csr_wr_addr_o = req_q.csr_addr;
            csr_wr_data_o = req_q.csr_data;
            regs_wen_o    = 1'b0;
            csr_wen_o     = 1'b0;
        end
        case (state_q)
            LsuIdle: begin
                if (flush_i || mem_req_i) begin
                    regs_wen_o = 1'b0;
                    csr_wen_o  = 1'b0;
                end
                if (!flush_i && mem_req_i && misalign) begin
                    misalign_o   = 1'b1;
                    fault_addr_o = mem_addr_i;
                end
            end
            LsuDone: begin
                if (!flush_i) begin
                    if (err_q || tmo_q) begin
                        fault_o      = 1'b1;
                        fault_addr_o = req_q.addr;
                    end else begin
                        regs_wen_o = req_q.regs_wen;
                        csr_wen_o  = req_q.csr_wen;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // State and capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LsuIdle;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stimulus pushes expected write-back results, a negedge monitor pops and checks.
module tb_mem_lsu;

    logic        clk, rst;
    logic [31:0] inst_i, instaddr_i, rd_data_i, csr_wr_data_i, mem_addr_i, mem_wdata_i;
    logic        regs_wen_i, csr_wen_i, mem_req_i, mem_we_i, mem_unsigned_i, flush_i;
    logic [4:0]  rd_addr_i;
    logic [11:0] csr_wr_addr_i;
    logic [1:0]  mem_size_i;
    logic        dbus_req_o, dbus_we_o, dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
    logic        stall_o, regs_wen_o, csr_wen_o, misalign_o, fault_o;
    logic [31:0] inst_o, instaddr_o, rd_data_o, csr_wr_data_o, fault_addr_o;
    logic [4:0]  rd_addr_o;
    logic [11:0] csr_wr_addr_o;

    mem_lsu #(.BUS_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_i(inst_i), .instaddr_i(instaddr_i),
        .regs_wen_i(regs_wen_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
        .csr_wen_i(csr_wen_i), .csr_wr_addr_i(csr_wr_addr_i), .csr_wr_data_i(csr_wr_data_i),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
        .mem_unsigned_i(mem_unsigned_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_be_o(dbus_be_o),
        .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_err_i(dbus_err_i),
        .dbus_rdata_i(dbus_rdata_i),
        .stall_o(stall_o),
        .inst_o(inst_o), .instaddr_o(instaddr_o), .regs_wen_o(regs_wen_o),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .csr_wen_o(csr_wen_o),
        .csr_wr_addr_o(csr_wr_addr_o), .csr_wr_data_o(csr_wr_data_o),
        .misalign_o(misalign_o), .fault_o(fault_o), .fault_addr_o(fault_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        regs_wen;
        logic        csr_wen;
        logic        chk_data;
        logic [31:0] rd_data;
        logic        fault;
        logic        misalign;
        logic [31:0] fault_addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   stall_cnt = 0;
    logic prev_stall = 1'b0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %h expected %h", nm, id, act, exp);
        end
    endtask

    task automatic push(input int id, input logic rw, input logic cw, input logic cd,
                        input logic [31:0] rd, input logic flt, input logic mis, input logic [31:0] fa);
        exp_t e;
        e.id = id; e.regs_wen = rw; e.csr_wen = cw; e.chk_data = cd; e.rd_data = rd;
        e.fault = flt; e.misalign = mis; e.fault_addr = fa;
        exp_q.push_back(e);
    endtask

    // Monitor: a result is presented on the first unstalled cycle after a stall, or on a misalign.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !stall_o && (prev_stall || misalign_o)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got rd_data %h with no expected entry", rd_data_o);
            end else begin
                e = exp_q.pop_front();
                chk("regs_wen_o", e.id, 32'(regs_wen_o), 32'(e.regs_wen));
                chk("csr_wen_o", e.id, 32'(csr_wen_o), 32'(e.csr_wen));
                chk("fault_o", e.id, 32'(fault_o), 32'(e.fault));
                chk("misalign_o", e.id, 32'(misalign_o), 32'(e.misalign));
                if (e.chk_data) chk("rd_data_o", e.id, rd_data_o, e.rd_data);
                if (e.fault || e.misalign) chk("fault_addr_o", e.id, fault_addr_o, e.fault_addr);
            end
        end
        prev_stall = rst ? 1'b0 : stall_o;
        if (stall_o) stall_cnt++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr();
        inst_i = 32'h0000_0013; instaddr_i = '0; regs_wen_i = 1'b0; rd_addr_i = '0; rd_data_i = '0;
        csr_wen_i = 1'b0; csr_wr_addr_i = '0; csr_wr_data_i = '0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = '0; mem_unsigned_i = 1'b0;
        mem_addr_i = '0; mem_wdata_i = '0; flush_i = 1'b0;
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0; dbus_rdata_i = '0;
    endtask

    task automatic mop(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic rw, input logic [31:0] rd);
        mem_req_i = 1'b1; mem_we_i = we; mem_size_i = sz; mem_unsigned_i = uns;
        mem_addr_i = a; mem_wdata_i = wd; regs_wen_i = rw; rd_data_i = rd; rd_addr_i = 5'd7;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        nxt(); nxt();
        rst = 1'b0;

        // Reset state and non-memory pass-through.
        regs_wen_i = 1'b1; rd_data_i = 32'h1111_1111; csr_wen_i = 1'b1;
        csr_wr_addr_i = 12'h300; csr_wr_data_i = 32'h0000_CAFE; inst_i = 32'h0040_0093;
        smp();
        chk("reset_dbus_req", 0, 32'(dbus_req_o), 0);
        chk("reset_stall", 0, 32'(stall_o), 0);
        chk("reset_misalign", 0, 32'(misalign_o), 0);
        chk("reset_fault", 0, 32'(fault_o), 0);
        chk("pass_regs_wen", 0, 32'(regs_wen_o), 1);
        chk("pass_rd_data", 0, rd_data_o, 32'h1111_1111);
        chk("pass_csr_wen", 0, 32'(csr_wen_o), 1);
        chk("pass_csr_data", 0, csr_wr_data_o, 32'h0000_CAFE);
        chk("pass_inst", 0, inst_o, 32'h0040_0093);

        // 1: LB 0x1003, minimum latency.
        nxt(); clr();
        mop(1'b0, 2'b00, 1'b0, 32'h0000_1003, '0, 1'b1, 32'hAAAA_0000);
        dbus_gnt_i = 1'b1; stall_cnt = 0;
        push(1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0, '0);
        smp();
        chk("lb_req", 1, 32'(dbus_req_o), 1);
        chk("lb_addr", 1, dbus_addr_o, 32'h0000_1000);
        chk("lb_be", 1, 32'(dbus_be_o), 32'h8);
        nxt(); dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h8012_3456;
        smp(); chk("lb_wait_req", 1, 32'(dbus_req_o), 0);
        nxt(); dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
        smp();
        nxt(); clr();
        chk("lb_stall_cycles", 1, stall_cnt, 2);

        // 2: SH 0x2002.
        mop(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 32'h0000_2002);
        dbus_gnt_i = 1'b1;
        push(2, 1'b0, 1'b0, 1'b1, 32'h0000_2002, 1'b0, 1'b0, '0);
        smp();
        chk("sh_addr", 2, dbus_addr_o, 32'h0000_2000);
        chk("sh_be", 2, 32'(dbus_be_o), 32'hC);
        chk("sh_wdata", 2, dbus_wdata_o, 32'hBEEF_BEEF);
        chk("sh_we", 2, 32'(dbus_we_o), 1);
        nxt(); dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b1;
        smp();
        nxt(); dbus_rvalid_i = 1'b0;
        smp();
        nxt(); clr();

        // 3: LW 0x3001, misaligned.
        mop(1'b0, 2'b10, 1'b0, 32'h0000_3001, '0, 1'b1, 32'h0000_3333);
        push(3, 1'b0, 1'b0, 1'b1, 32'h0000_3333, 1'b0, 1'b1, 32'h0000_3001);
        smp();
        chk("mis_req", 3, 32'(dbus_req_o), 0);
        chk("mis_stall", 3, 32'(stall_o), 0);
        nxt(); clr();
        smp(); chk("mis_clear", 3, 32'(misalign_o), 0);

        // 4: LHU 0x4002, gnt withheld 3 cycles, rvalid+err on the timeout cycle.
        nxt();
        mop(1'b0, 2'b01, 1'b1, 32'h0000_4002, '0, 1'b1, 32'h0000_4444);
        stall_cnt = 0;
        push(4, 1'b0, 1'b0, 1'b1, 32'h0000_ABCD, 1'b1, 1'b0, 32'h0000_4002);
        smp(); chk("lhu_be", 4, 32'(dbus_be_o), 32'hC);
        nxt(); smp(); chk("lhu_req_hold", 4, 32'(dbus_req_o), 1);
        chk("lhu_req_addr", 4, dbus_addr_o, 32'h0000_4000);
        nxt(); smp();
        nxt(); dbus_gnt_i = 1'b1; smp(); chk("lhu_req_gnt", 4, 32'(dbus_req_o), 1);
        nxt(); dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b1; dbus_err_i = 1'b1; dbus_rdata_i = 32'hABCD_1234;
        smp(); chk("lhu_wait_req", 4, 32'(dbus_req_o), 0);
        nxt(); dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0;
        smp();
        nxt(); clr();
        chk("lhu_stall_cycles", 4, stall_cnt, 5);

        // 5: LW 0x5004, rvalid without error on the last allowed WAIT cycle.
        mop(1'b0, 2'b10, 1'b0, 32'h0000_5004, '0, 1'b1, 32'h0000_5555);
        dbus_gnt_i = 1'b1; stall_cnt = 0;
        push(5, 1'b1, 1'b0, 1'b1, 32'h5A5A_1234, 1'b0, 1'b0, '0);
        smp();
        nxt(); dbus_gnt_i = 1'b0; smp();
        nxt(); smp();
        nxt(); smp();
        nxt(); dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h5A5A_1234; smp();
        nxt(); dbus_rvalid_i = 1'b0; smp();
        nxt(); clr();
        chk("lw_edge_stall_cycles", 5, stall_cnt, 5);

        // 6: LW 0x6000, granted, never answered -> timeout fault.
        mop(1'b0, 2'b10, 1'b0, 32'h0000_6000, '0, 1'b1, 32'h0000_6666);
        dbus_gnt_i = 1'b1; stall_cnt = 0;
        push(6, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h0000_6000);
        smp();
        nxt(); dbus_gnt_i = 1'b0; smp();
        nxt(); smp();
        nxt(); smp();
        nxt(); smp(); chk("tmo_last_wait_stall", 6, 32'(stall_o), 1);
        nxt(); smp();
        nxt(); clr();
        smp();
        chk("tmo_idle_stall", 6, 32'(stall_o), 0);
        chk("tmo_idle_fault", 6, 32'(fault_o), 0);
        chk("tmo_stall_cycles", 6, stall_cnt, 5);

        // 7: flush on an aligned op in IDLE.
        nxt();
        mop(1'b0, 2'b10, 1'b0, 32'h0000_7000, '0, 1'b1, 32'h0000_7777);
        csr_wen_i = 1'b1; flush_i = 1'b1; dbus_gnt_i = 1'b1;
        smp();
        chk("flush_idle_req", 7, 32'(dbus_req_o), 0);
        chk("flush_idle_stall", 7, 32'(stall_o), 0);
        chk("flush_idle_regs_wen", 7, 32'(regs_wen_o), 0);
        chk("flush_idle_csr_wen", 7, 32'(csr_wen_o), 0);
        nxt(); clr();
        smp(); chk("flush_idle_no_issue", 7, 32'(stall_o), 0);

        // 8: flush in WAIT -> DRAIN; the following LBU issues only after the late rvalid.
        nxt();
        mop(1'b0, 2'b10, 1'b0, 32'h0000_8000, '0, 1'b1, 32'h0000_8888);
        dbus_gnt_i = 1'b1;
        smp();
        nxt(); dbus_gnt_i = 1'b0; flush_i = 1'b1;
        smp(); chk("flush_wait_stall", 8, 32'(stall_o), 1);
        nxt(); flush_i = 1'b0;
        mop(1'b0, 2'b00, 1'b1, 32'h0000_9001, '0, 1'b1, 32'h0000_9999);
        smp();
        chk("drain_stall", 8, 32'(stall_o), 1);
        chk("drain_no_req", 8, 32'(dbus_req_o), 0);
        chk("drain_regs_wen", 8, 32'(regs_wen_o), 0);
        nxt(); dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hFFFF_FFFF;
        smp();
        chk("drain_rvalid_stall", 8, 32'(stall_o), 1);
        chk("drain_rvalid_no_req", 8, 32'(dbus_req_o), 0);
        nxt(); dbus_rvalid_i = 1'b0; dbus_rdata_i = '0; dbus_gnt_i = 1'b1;
        push(9, 1'b1, 1'b0, 1'b1, 32'h0000_00AB, 1'b0, 1'b0, '0);
        smp();
        chk("after_drain_req", 9, 32'(dbus_req_o), 1);
        chk("after_drain_addr", 9, dbus_addr_o, 32'h0000_9000);
        chk("after_drain_be", 9, 32'(dbus_be_o), 32'h2);
        nxt(); dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h0000_AB00;
        smp();
        nxt(); dbus_rvalid_i = 1'b0;
        smp();
        nxt(); clr();

        // 10: SW with size code 11 at 0xB000 behaves as a word store.
        mop(1'b1, 2'b11, 1'b0, 32'h0000_B000, 32'h1234_5678, 1'b0, 32'h0000_B000);
        dbus_gnt_i = 1'b1;
        push(10, 1'b0, 1'b0, 1'b1, 32'h0000_B000, 1'b0, 1'b0, '0);
        smp();
        chk("sw11_be", 10, 32'(dbus_be_o), 32'hF);
        chk("sw11_wdata", 10, dbus_wdata_o, 32'h1234_5678);
        nxt(); dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b1;
        smp();
        nxt(); dbus_rvalid_i = 1'b0;
        smp();
        nxt(); clr();

        // 11: reset while waiting; a stale rvalid afterwards is ignored.
        mop(1'b0, 2'b10, 1'b0, 32'h0000_A000, '0, 1'b1, 32'h0000_AAAA);
        dbus_gnt_i = 1'b1;
        smp();
        nxt(); dbus_gnt_i = 1'b0; rst = 1'b1;
        smp();
        nxt(); rst = 1'b0; clr(); dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hDEAD_BEEF;
        smp();
        chk("rst_mid_stall", 11, 32'(stall_o), 0);
        chk("rst_mid_req", 11, 32'(dbus_req_o), 0);
        chk("rst_mid_fault", 11, 32'(fault_o), 0);
        nxt(); clr();
        smp(); chk("rst_stale_stall", 11, 32'(stall_o), 0);

        nxt();
        chk("scoreboard_empty", 99, exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
